gsim_residual_chk: RTL and testbench
====================================

Name: gsim_residual_chk

Overview:
- Downstream checker for the GSIM solver.
- Taps the same b stream fed to GSIM (in_en/b_in) and consumes GSIM's x stream (out_valid/x_out).
- Computes the fixed-point residual r_i = b_i·2^16 − (A·x)_i for every row of the fixed 16×16 banded matrix A, and streams each r_i out.
- Tracks the largest |r_i| and raises pass/done so the system can decide whether to accept the solution or re-iterate.
- A: diagonal 20, ±1 off-diagonal −13, ±2 → 6, ±3 → −1, zero elsewhere (truncated at matrix edges).

Parameters:
- N, 16, vector length / rows of A (block supports N=16 only; parameter kept for package consistency)
- BW, 16, b word width, signed integer
- XW, 32, x word width, signed Q16.16
- RW, 40, residual width, signed Q24.16
- TOL, 40'd64, pass threshold on max |r| (64/65536 ≈ 0.001)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_en  in  1  b word valid (same strobe driven into GSIM)
- b_in  in  16  b word, signed
- x_valid  in  1  connect to GSIM out_valid
- x_in  in  32  connect to GSIM x_out, signed Q16.16
- r_valid  out  1  residual word valid, 1-cycle pulse per row
- r_idx  out  4  row index of r_out
- r_out  out  40  residual, signed Q24.16
- max_abs_r  out  40  running max |r|, unsigned
- done  out  1  high from the cycle after the last residual until the next frame starts
- pass  out  1  valid while done; 1 iff max_abs_r <= TOL
- protocol_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, FSM in IDLE, counters 0, b_mem contents don't-care.
- FSM states: IDLE, LOAD_B, RUN, FLUSH, DONE.
  - IDLE/DONE + in_en → LOAD_B. That in_en word is stored as b[0]. Entering LOAD_B clears done, pass and max_abs_r.
  - LOAD_B: each in_en stores b_in at b_mem[bcnt] and increments bcnt. On the 16th word → RUN.
  - RUN: each x_valid shifts x_in into a 7-tap window (w[0] newest). Window is zero-filled on entry to RUN, so it behaves as zero padding at the edges. xcnt increments per sample. Gaps in x_valid are allowed; the window holds.
  - After the sample with index j ≥ 3 is captured, row i = j−3 is computed. Result is registered: r_valid, r_idx=i and r_out appear the cycle after the capture edge.
  - After x[15]: → FLUSH. FLUSH shifts zero for 3 consecutive cycles, emitting rows 13, 14, 15 on the following cycles. Then → DONE.
  - DONE: done=1, pass valid. Both hold until a new frame starts.
- Arithmetic:
  - Row sum = Σ c_k·x over the window taps, computed in RW bits with sign extension.
  - Constant multiplies are implemented as shift-adds (20=16+4, 13=8+4+1, 6=4+2).
  - b term = sign-extended b << 16.
  - r = bterm − sum; no saturation (RW covers worst case 60·2^31 + 2^31).
  - |r| is computed in RW bits. max_abs_r updates in the same cycle r_valid is asserted.
- Boundaries and errors:
  - in_en outside IDLE/LOAD_B/DONE: word ignored, protocol_err set.
  - x_valid outside RUN (early x or extra x): sample dropped, protocol_err set.
  - x_valid during FLUSH: dropped, protocol_err set, flush not disturbed.
  - Simultaneous in_en and x_valid in RUN: x accepted, in_en flagged.
  - Reset mid-frame: immediate return to IDLE, no partial outputs.
  - Back-to-back frames: in_en in DONE starts the next frame with zero dead cycles.

Decomposition:
- Package gsim_pkg holds: N, BW, XW, RW; coefficient localparams C0=20, C1=−13, C2=6, C3=−1; FSM state enum; TOL default.
- One sub-module, gsim_row_mac: purely combinational 7-tap banded dot product plus b subtraction (window + b → r). Keeps the shift-add tree separately testable.
- The top level holds b_mem, the window, counters, FSM and output registers.

Test Plan:
- x = e0 (x[0]=0x00010000, rest 0), b = {20,−13,6,−1,0…0} → all 16 r_out = 0, max_abs_r=0, done=1, pass=1.
- b all 0, x[5]=0x00010000 → r[5]=−1310720, r[4]=r[6]=851968, r[3]=r[7]=−393216, r[2]=r[8]=65536, others 0; max_abs_r=1310720, pass=0.
- Same as case 1 but x_valid toggled every other cycle → identical r sequence; r_idx strictly 0..15; each r_valid one cycle after capture of x[i+3] (last three during FLUSH).
- x_valid asserted during LOAD_B (bcnt=8) → sample dropped, protocol_err=1 and remains 1 after done.
- Reset pulsed asynchronously mid-RUN (xcnt=7) → all outputs 0 immediately; a fresh full frame afterwards yields case 1 results.
- Two frames back-to-back (case 1 then case 2, in_en in the first DONE cycle) → done drops, max_abs_r clears, second frame results exactly as in case 2.

Source files
------------

// File: rtl/gsim_pkg.sv
// Shared widths, banded-matrix coefficients, FSM encoding and pass threshold for the GSIM residual checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gsim_pkg;

    localparam int N  = 16;   // vector length / rows of A
    localparam int BW = 16;   // b word width, signed integer
    localparam int XW = 32;   // x word width, signed Q16.16
    localparam int RW = 40;   // residual width, signed Q24.16

    // Band of A: diagonal, then distance 1, 2 and 3 from the diagonal
    localparam int C0 = 20;
    localparam int C1 = -13;
    localparam int C2 = 6;
    localparam int C3 = -1;

    // Pass threshold on max |r| (64/65536 is roughly 0.001)
    localparam logic [RW-1:0] TOL = 40'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_B,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } gsim_state_e;

endpackage

// File: rtl/gsim_row_mac.sv
// Banded 7-tap dot product of one matrix row against the x window, subtracted from b scaled to Q24.16.
// Latency: purely combinational.
// Backpressure: none; result follows the inputs.
// Ports: win (7 taps, win[0] newest, win[3] is the row's diagonal element), b (signed integer), r (b*2^16 - row sum).
module gsim_row_mac
    import gsim_pkg::*;
(
    input  logic [6:0][XW-1:0]   win,
    input  logic signed [BW-1:0] b,
    output logic signed [RW-1:0] r
);

    function automatic logic [RW-1:0] sx(input logic [XW-1:0] v);
        return {{(RW-XW){v[XW-1]}}, v};
    endfunction

    logic signed [RW-1:0] t0, t1, t2, t3;
    logic signed [RW-1:0] p0, p1, p2, p3;
    logic signed [RW-1:0] sum, bterm;

    always_comb begin
        // Symmetric band: pair taps equidistant from the diagonal before multiplying
        t0 = sx(win[3]);
        t1 = sx(win[2]) + sx(win[4]);
        t2 = sx(win[1]) + sx(win[5]);
        t3 = sx(win[0]) + sx(win[6]);

        // Magnitudes as shift-add trees: 20 = 16+4, 13 = 8+4+1, 6 = 4+2, 1
        p0 = (t0 <<< 4) + (t0 <<< 2);
        p1 = (t1 <<< 3) + (t1 <<< 2) + t1;
        p2 = (t2 <<< 2) + (t2 <<< 1);
        p3 = t3;

        // Signs are taken from the package coefficients; these fold away at elaboration
        sum = ((C0 < 0) ? -p0 : p0)
            + ((C1 < 0) ? -p1 : p1)
            + ((C2 < 0) ? -p2 : p2)
            + ((C3 < 0) ? -p3 : p3);

        bterm = {{(RW-BW-16){b[BW-1]}}, b, 16'b0};
        r     = bterm - sum;
    end

endmodule

// File: rtl/gsim_residual_chk.sv
// Residual checker: loads b, streams x through a 7-tap window and emits r_i = b_i*2^16 - (A*x)_i per row, tracking max |r|.
// Latency: r_valid one cycle after the capture of x[i+3]; rows 13..15 follow x[15] by 2..4 cycles; done one cycle after row 15.
// Backpressure: none; words arriving in the wrong phase are dropped and flagged on the sticky protocol_err.
// Ports: clk/reset (async, active high); in_en/b_in b stream; x_valid/x_in x stream;
//        r_valid/r_idx/r_out residual stream; max_abs_r, done, pass, protocol_err status.
module gsim_residual_chk
    import gsim_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    input  logic [BW-1:0] b_in,
    input  logic          x_valid,
    input  logic [XW-1:0] x_in,
    output logic          r_valid,
    output logic [3:0]    r_idx,
    output logic [RW-1:0] r_out,
    output logic [RW-1:0] max_abs_r,
    output logic          done,
    output logic          pass,
    output logic          protocol_err
);

    gsim_state_e       state_q, state_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [3:0]        xcnt_q, xcnt_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic [6:0][XW-1:0] win_q, win_d;
    logic              calc_q, calc_d;     // window holds a complete row this cycle
    logic [3:0]        cidx_q, cidx_d;     // row index that window belongs to
    logic              r_vld_q, r_vld_d;
    logic [3:0]        r_idx_q, r_idx_d;
    logic [RW-1:0]     r_out_q, r_out_d;
    logic [RW-1:0]     max_q, max_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              err_q, err_d;

    logic [BW-1:0]     b_mem_q [N];
    logic              b_we;
    logic [3:0]        b_wa;

    logic signed [RW-1:0] r_row;
    logic [RW-1:0]        abs_r;

    gsim_row_mac u_mac (
        .win (win_q),
        .b   (b_mem_q[cidx_q]),
        .r   (r_row)
    );

    assign abs_r = r_row[RW-1] ? -r_row : r_row;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        xcnt_d  = xcnt_q;
        fcnt_d  = fcnt_q;
        win_d   = win_q;
        calc_d  = 1'b0;
        cidx_d  = cidx_q;
        r_vld_d = 1'b0;
        r_idx_d = r_idx_q;
        r_out_d = r_out_q;
        max_d   = max_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        b_we    = 1'b0;
        b_wa    = bcnt_q;

        // Output stage: register the row prepared on the previous edge
        if (calc_q) begin
            r_vld_d = 1'b1;
            r_idx_d = cidx_q;
            r_out_d = r_row;
            if (abs_r > max_q) begin
                max_d = abs_r;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_en) begin
                    state_d = ST_LOAD_B;
                    b_we    = 1'b1;
                    b_wa    = 4'd0;
                    bcnt_d  = 4'd1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    max_d   = '0;
                end
                if (x_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_LOAD_B: begin
                if (in_en) begin
                    b_we   = 1'b1;
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q == 4'(N-1)) begin
                        state_d = ST_RUN;
                        xcnt_d  = 4'd0;
                        win_d   = '0;   // zero padding ahead of x[0]
                    end
                end
                if (x_valid) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_en) begin
                    err_d = 1'b1;
                end
                if (x_valid) begin
                    win_d  = {win_q[5:0], x_in};
                    xcnt_d = xcnt_q + 4'd1;
                    if (xcnt_q >= 4'd3) begin
                        calc_d = 1'b1;
                        cidx_d = xcnt_q - 4'd3;
                    end
                    if (xcnt_q == 4'(N-1)) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = 3'd0;
                    end
                end
            end
            ST_FLUSH: begin
                if (in_en || x_valid) begin
                    err_d = 1'b1;
                end
                fcnt_d = fcnt_q + 3'd1;
                // Three zero shifts close out rows 13..15; two more cycles let row 15 land in max
                if (fcnt_q < 3'd3) begin
                    win_d  = {win_q[5:0], {XW{1'b0}}};
                    calc_d = 1'b1;
                    cidx_d = 4'(N-3) + {2'b00, fcnt_q[1:0]};
                end
                if (fcnt_q == 3'd4) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (max_q <= TOL);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            xcnt_q  <= '0;
            fcnt_q  <= '0;
            win_q   <= '0;
            calc_q  <= 1'b0;
            cidx_q  <= '0;
            r_vld_q <= 1'b0;
            r_idx_q <= '0;
            r_out_q <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            xcnt_q  <= xcnt_d;
            fcnt_q  <= fcnt_d;
            win_q   <= win_d;
            calc_q  <= calc_d;
            cidx_q  <= cidx_d;
            r_vld_q <= r_vld_d;
            r_idx_q <= r_idx_d;
            r_out_q <= r_out_d;
            max_q   <= max_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    // b storage needs no reset: every frame rewrites all rows before they are read
    always_ff @(posedge clk) begin
        if (b_we) begin
            b_mem_q[b_wa] <= b_in;
        end
    end

    assign r_valid      = r_vld_q;
    assign r_idx        = r_idx_q;
    assign r_out        = r_out_q;
    assign max_abs_r    = max_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_gsim_residual_chk.sv
module tb_gsim_residual_chk;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [15:0] b_in;
    logic        x_valid;
    logic [31:0] x_in;
    logic        r_valid;
    logic [3:0]  r_idx;
    logic [39:0] r_out;
    logic [39:0] max_abs_r;
    logic        done;
    logic        pass;
    logic        protocol_err;

    gsim_residual_chk dut (
        .clk          (clk),
        .reset        (reset),
        .in_en        (in_en),
        .b_in         (b_in),
        .x_valid      (x_valid),
        .x_in         (x_in),
        .r_valid      (r_valid),
        .r_idx        (r_idx),
        .r_out        (r_out),
        .max_abs_r    (max_abs_r),
        .done         (done),
        .pass         (pass),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Frame data and scoreboard
    logic signed [15:0] bv [16];
    logic signed [31:0] xv [16];
    int                 kv [16];
    int                 exp_idx_q [$];
    longint             exp_r_q   [$];
    int                 exp_cyc_q [$];
    longint             exp_max;
    longint             exp_pass;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int coef(input int d);
        int a;
        a = (d < 0) ? -d : d;
        case (a)
            0:       return 20;
            1:       return -13;
            2:       return 6;
            3:       return -1;
            default: return 0;
        endcase
    endfunction

    // Reference: full dense matrix-vector product in 64-bit integers
    task automatic model();
        longint acc, a;
        exp_max = 0;
        for (int i = 0; i < 16; i++) begin
            acc = longint'(bv[i]) * 65536;
            for (int j = 0; j < 16; j++) begin
                acc = acc - longint'(coef(i - j)) * longint'(xv[j]);
            end
            exp_idx_q.push_back(i);
            exp_r_q.push_back(acc);
            a = (acc < 0) ? -acc : acc;
            if (a > exp_max) exp_max = a;
        end
        exp_pass = (exp_max <= 64) ? 1 : 0;
    endtask

    // Monitor: every r_valid pops one expected row
    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (exp_r_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_r: got row %0d expected none", r_idx);
            end else begin
                chk("r_idx", longint'(r_idx), longint'(exp_idx_q.pop_front()));
                chk("r_out", longint'($signed(r_out)), exp_r_q.pop_front());
                if (exp_cyc_q.size() == 0) chk("r_timing_q", 0, 1);
                else chk("r_cycle", longint'(cyc), longint'(exp_cyc_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input int inj_at, input bit b2b);
        for (int i = 0; i < 16; i++) begin
            in_en = 1'b1;
            b_in  = bv[i];
            if (i == inj_at) begin
                x_valid = 1'b1;
                x_in    = $urandom();
            end
            tick();
            x_valid = 1'b0;
            if (b2b && i == 0) begin
                chk("b2b_done_drop", longint'(done), 0);
                chk("b2b_max_clear", longint'(max_abs_r), 0);
                chk("b2b_pass_clear", longint'(pass), 0);
            end
        end
        in_en = 1'b0;
    endtask

    // gapmode 0: dense, 1: one idle cycle between samples, 2: random idle runs
    task automatic send_x(input int gapmode, input int nx);
        int cap, g;
        for (int j = 0; j < nx; j++) begin
            g = 0;
            if (gapmode == 1 && j > 0) g = 1;
            if (gapmode == 2 && $urandom_range(0, 2) == 0) g = $urandom_range(1, 3);
            for (int k = 0; k < g; k++) tick();
            x_valid = 1'b1;
            x_in    = xv[j];
            cap     = cyc + 1;
            if (j >= 3) exp_cyc_q.push_back(cap + 1);
            if (j == 15) begin
                exp_cyc_q.push_back(cap + 2);
                exp_cyc_q.push_back(cap + 3);
                exp_cyc_q.push_back(cap + 4);
            end
            tick();
            x_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            chk({tag, "_done_timeout"}, longint'(done), 1);
        end else begin
            chk({tag, "_max"}, longint'(max_abs_r), exp_max);
            chk({tag, "_pass"}, longint'(pass), exp_pass);
            chk({tag, "_rows_left"}, longint'(exp_r_q.size()), 0);
        end
    endtask

    task automatic run_frame(input string tag, input int gapmode, input int inj_at, input bit b2b);
        model();
        send_b(inj_at, b2b);
        send_x(gapmode, 16);
        wait_done(tag);
    endtask

    task automatic set_case1();
        for (int i = 0; i < 16; i++) begin
            bv[i] = '0;
            xv[i] = '0;
        end
        xv[0] = 32'h0001_0000;
        bv[0] = 16'sd20;
        bv[1] = -16'sd13;
        bv[2] = 16'sd6;
        bv[3] = -16'sd1;
    endtask

    task automatic set_case2();
        for (int i = 0; i < 16; i++) begin
            bv[i] = '0;
            xv[i] = '0;
        end
        xv[5] = 32'h0001_0000;
    endtask

    initial begin
        reset   = 1'b1;
        in_en   = 1'b0;
        b_in    = '0;
        x_valid = 1'b0;
        x_in    = '0;
        #12;
        chk("rst_r_valid", longint'(r_valid), 0);
        chk("rst_r_out", longint'(r_out), 0);
        chk("rst_max", longint'(max_abs_r), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pass", longint'(pass), 0);
        chk("rst_err", longint'(protocol_err), 0);
        reset = 1'b0;
        tick();

        // Known-answer frames, the second started in the first DONE cycle of the first
        set_case1();
        run_frame("case1", 0, -1, 1'b0);
        set_case2();
        run_frame("case2", 0, -1, 1'b1);
        chk("case2_max_const", longint'(max_abs_r), 1310720);
        set_case1();
        run_frame("case1_gappy", 1, -1, 1'b0);

        // Fully random frames
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) begin
                bv[i] = 16'($urandom());
                xv[i] = 32'($urandom());
            end
            run_frame("rand", 2, -1, 1'b0);
        end

        // Near-solution frames: x close to integer vector k, b = A*k, so |r| straddles TOL
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 16; j++) begin
                kv[j] = int'($urandom_range(0, 8)) - 4;
                xv[j] = 32'(kv[j] * 65536 + int'($urandom_range(0, 4)) - 2);
            end
            for (int i = 0; i < 16; i++) begin
                int s = 0;
                for (int j = 0; j < 16; j++) s += coef(i - j) * kv[j];
                bv[i] = 16'(s);
            end
            run_frame("near", 2, -1, 1'b0);
        end
        chk("err_clean", longint'(protocol_err), 0);

        // x during LOAD_B at bcnt=8: dropped and flagged, results unchanged
        set_case2();
        model();
        send_b(8, 1'b0);
        chk("err_set", longint'(protocol_err), 1);
        send_x(0, 16);
        wait_done("case4");
        chk("err_after_done", longint'(protocol_err), 1);

        // Abort mid-RUN after 7 samples
        set_case2();
        model();
        send_b(-1, 1'b0);
        send_x(0, 7);
        tick();
        tick();
        chk("err_sticky_frame", longint'(protocol_err), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_r_valid", longint'(r_valid), 0);
        chk("abort_r_idx", longint'(r_idx), 0);
        chk("abort_r_out", longint'(r_out), 0);
        chk("abort_max", longint'(max_abs_r), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_err", longint'(protocol_err), 0);
        chk("abort_rows_seen", longint'(exp_r_q.size()), 12);
        exp_idx_q.delete();
        exp_r_q.delete();
        exp_cyc_q.delete();
        #3 reset = 1'b0;
        tick();
        set_case1();
        run_frame("after_abort", 0, -1, 1'b0);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
